// File: rtl/gnrl_fifo.sv
// ---------------------------------------------------------------------------
// gnrl_fifo
// General-purpose single-clock FIFO with valid/ready handshakes on both the
// write side and the read side. It is used as a decoupling buffer between
// pipeline stages and peripheral data paths.
//
// Parameters:
//   DW - data word width in bits (>= 1)
//   DP - depth in entries (power of 2, >= 2)
//   AW - pointer index width, derived as log2(DP)
//
// Ports:
//   clk    - system clock, rising-edge active
//   rstn   - asynchronous active-low reset
//   i_vld  - producer has a word on i_dat
//   i_rdy  - FIFO can accept a word (not full)
//   i_dat  - write data
//   o_vld  - FIFO presents a word on o_dat
//   o_rdy  - consumer takes o_dat this cycle
//   o_dat  - head-of-queue data
//   o_cnt  - number of stored entries, 0..DP
//
// Optional feature (macro GNRL_FIFO_BYPASS_EN):
//   When the macro is defined and the FIFO is empty, an incoming word is
//   shown on the read side in the same cycle. If the consumer takes it in
//   that cycle, the word is never stored. Without the macro, the read side
//   depends only on registered state.
// ---------------------------------------------------------------------------
module gnrl_fifo #(
    parameter  int DW = 32,
    parameter  int DP = 4,
    localparam int AW = $clog2(DP)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [AW:0]   o_cnt
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DW-1:0] mem [DP];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          full;
    logic          wen;
    logic          ren;

    // The pointers carry one extra wrap bit. Equal indices mean either empty
    // or full, and the wrap bit tells the two cases apart.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    assign i_rdy = !full;

`ifdef GNRL_FIFO_BYPASS_EN
    // A word arriving while the FIFO is empty goes straight to the read side.
    // It is written into storage only when the consumer does not take it now.
    logic bypass;
    assign bypass = empty && i_vld;
    assign o_vld  = !empty || bypass;
    assign o_dat  = empty ? i_dat : mem[rptr[AW-1:0]];
    assign wen    = i_vld && i_rdy && !(bypass && o_rdy);
    assign ren    = !empty && o_rdy;
`else
    assign o_vld  = !empty;
    assign o_dat  = mem[rptr[AW-1:0]];
    assign wen    = i_vld && i_rdy;
    assign ren    = o_vld && o_rdy;
`endif

    // Storage: only the entry addressed by the write pointer loads on a push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DP; i++) begin
                mem[i] <= '0;
            end
        end else if (wen) begin
            mem[wptr[AW-1:0]] <= i_dat;
        end
    end

    // Pointers advance on their own handshake. They wrap by natural overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wen) begin
                wptr <= wptr + PTR_ONE;
            end
            if (ren) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // The occupancy counter holds when a push and a pop happen together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_cnt <= '0;
        end else begin
            case ({wen, ren})
                2'b10:   o_cnt <= o_cnt + PTR_ONE;
                2'b01:   o_cnt <= o_cnt - PTR_ONE;
                default: o_cnt <= o_cnt;
            endcase
        end
    end

endmodule
